de2_115_qsys_sma_out: RTL
=========================

DE2_115_QSYS_SMA_OUT -- requirements
Module: de2_115_qsys_sma_out

Interface
REQ-001 Parameter CNT_W, default 16: width of the HIGH/LOW phase counters and registers (2..32).
REQ-002 Parameter RESET_VALUE, default 0: reset level of the DATA bit and of out_port.
REQ-003 Reset reset_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  2  Avalon-MM word address: 0 DATA, 1 CTRL, 2 HIGH_CNT, 3 LOW_CNT.
REQ-007 chipselect  input  1  slave select; a write is chipselect=1 and write_n=0.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data; unused upper bits 0.
REQ-011 out_port  output  1  registered SMA output level.

Function
REQ-012 Zero wait states; every write is accepted in the cycle it is presented.
REQ-013 readdata updates every clk edge from address; 1-cycle latency; no read strobe.
REQ-014 Read map: 0 -> {31'b0, out_port}; 1 -> {27'b0, busy, 1'b0, 1'b0, cont, mode}; 2 -> zero-extended HIGH_CNT; 3 -> zero-extended LOW_CNT.
REQ-015 DATA write: data_bit <= writedata[0].
REQ-016 CTRL write: mode <= writedata[0]; cont <= writedata[1]; writedata[2] = START pulse; writedata[3] = STOP pulse; START/STOP are not stored.
REQ-017 HIGH_CNT/LOW_CNT writes: store writedata[CNT_W-1:0]; a value of 0 is treated as 1.
REQ-018 Pulse FSM states IDLE, HIGH, LOW; busy = (state != IDLE).
REQ-019 IDLE -> HIGH on a CTRL write with START=1, STOP=0 and writedata[0]=1; counter loads max(HIGH_CNT,1).
REQ-020 out_port = 1 in HIGH, 0 in LOW; in IDLE, out_port = data_bit when mode=0, else 0.
REQ-021 out_port rises at the same edge that samples the START write and stays 1 for exactly max(HIGH_CNT,1) cycles.
REQ-022 HIGH end: cont=1 -> LOW with counter = max(LOW_CNT,1); cont=0 -> IDLE.
REQ-023 LOW end: cont=1 -> HIGH (counter reloaded); cont=0 -> IDLE; period = max(HIGH,1)+max(LOW,1).
REQ-024 HIGH_CNT/LOW_CNT writes while busy do not alter the running phase; they apply at the next phase load.
REQ-025 START while busy is ignored; START and STOP in the same write: STOP wins.
REQ-026 STOP, or a CTRL write with writedata[0]=0, while busy -> IDLE at that edge; out_port follows REQ-020 from that edge.

Reset
REQ-027 Reset: state IDLE, counter 0, mode 0, cont 0, data_bit RESET_VALUE, out_port RESET_VALUE, readdata 0, HIGH_CNT 1, LOW_CNT 1.
REQ-028 Reset asserted mid-pulse aborts immediately and asynchronously; no pulse resumes after release.

Configuration
REQ-029 Macro SMA_OUT_PULSE_EN defined: pulse engine per REQ-016..026 compiled in.
REQ-030 Macro SMA_OUT_PULSE_EN undefined: no FSM or counters; out_port = data_bit; CTRL/HIGH_CNT/LOW_CNT writes ignored and read 0.

Structure
REQ-031 Package de2_115_qsys_sma_out_pkg holds the address constants, CTRL bit positions and the IDLE/HIGH/LOW state enum.
REQ-032 Sub-module sma_out_pulse_gen holds the FSM and phase counter; the top holds the register file and read mux.

Verification
REQ-033 Static: write DATA=1 with mode=0 -> out_port=1 from the next edge; read address 0 -> 0x00000001 one cycle later.
REQ-034 One-shot: HIGH_CNT=5, CTRL=0x5 -> out_port high exactly 5 cycles, then 0; CTRL read shows busy=1 during the pulse and 0 after.
REQ-035 Continuous: HIGH_CNT=3, LOW_CNT=2, CTRL=0x7 -> repeating 3-high/2-low waveform, period 5; CTRL=0x9 mid-HIGH -> out_port 0 at that edge.
REQ-036 Boundary: HIGH_CNT=0 one-shot -> exactly 1-cycle pulse; START+STOP in one write (CTRL=0xD) -> no pulse.
REQ-037 Reset mid-continuous run -> out_port=RESET_VALUE immediately; after release, registers at reset values and no pulse.
REQ-038 Build without SMA_OUT_PULSE_EN -> CTRL=0x5 produces no pulse; addresses 1..3 read 0; DATA path is unchanged.

Source files
------------

// File: rtl/de2_115_qsys_sma_out_pkg.sv
// -----------------------------------------------------------------------------
// de2_115_qsys_sma_out_pkg
// Purpose : shared constants for the SMA output peripheral. It defines the
//           Avalon-MM word addresses, the CTRL register bit positions and the
//           state encoding of the pulse engine.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package de2_115_qsys_sma_out_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_HIGH_CNT = 2'd2;
  localparam logic [1:0] ADDR_LOW_CNT  = 2'd3;

  // CTRL register bit positions (START/STOP are write-only pulses)
  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;
  localparam int CTRL_BUSY_BIT  = 4;

  // Pulse engine states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/sma_out_pulse_gen.sv
// -----------------------------------------------------------------------------
// sma_out_pulse_gen
// Purpose : pulse FSM (IDLE/HIGH/LOW) and its phase down-counter. It is only
//           instantiated when SMA_OUT_PULSE_EN is defined.
// Ports   : clk, reset_n    - clock, asynchronous active-low reset
//           ctrl_wr         - CTRL register write this cycle
//           start, stop, run- writedata START / STOP / MODE bits of that write
//           cont            - stored continuous-mode flag
//           high_cnt,low_cnt- stored phase lengths (0 behaves as 1)
//           busy            - registered state != IDLE
//           active_next     - state after this edge != IDLE
//           level_next      - state after this edge == HIGH
// -----------------------------------------------------------------------------
module sma_out_pulse_gen
  import de2_115_qsys_sma_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_wr,
  input  logic             start,
  input  logic             stop,
  input  logic             run,
  input  logic             cont,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  output logic             busy,
  output logic             active_next,
  output logic             level_next
);

  pulse_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] high_load, low_load;

  // A programmed length of 0 is run as a single cycle.
  assign high_load = (high_cnt == '0) ? CNT_W'(1) : high_cnt;
  assign low_load  = (low_cnt  == '0) ? CNT_W'(1) : low_cnt;

  always_comb begin
    state_next = state;
    count_next = count;
    if (ctrl_wr && (state != IDLE) && (stop || !run)) begin
      // Abort takes priority; clearing MODE also stops a running pulse.
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_wr && start && !stop && run) begin
            state_next = HIGH;
            count_next = high_load;
          end
        end
        HIGH: begin
          if (count <= CNT_W'(1)) begin
            state_next = cont ? LOW : IDLE;
            count_next = cont ? low_load : '0;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
        LOW: begin
          if (count <= CNT_W'(1)) begin
            state_next = cont ? HIGH : IDLE;
            count_next = cont ? high_load : '0;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign busy        = (state != IDLE);
  assign active_next = (state_next != IDLE);
  assign level_next  = (state_next == HIGH);

endmodule

// File: rtl/de2_115_qsys_sma_out.sv
// -----------------------------------------------------------------------------
// de2_115_qsys_sma_out
// Purpose : Avalon-MM slave that drives a single SMA output. DATA sets a static
//           level. When SMA_OUT_PULSE_EN is defined, a pulse engine can also
//           produce one-shot or continuous HIGH/LOW waveforms. Without the
//           macro, out_port simply follows DATA.
// Ports   : clk, reset_n             - clock, asynchronous active-low reset
//           address, chipselect,
//           write_n, writedata       - Avalon-MM write (zero wait states)
//           readdata                 - registered read data, 1-cycle latency
//           out_port                 - registered SMA output level
// Macro   : SMA_OUT_PULSE_EN
// -----------------------------------------------------------------------------
module de2_115_qsys_sma_out
  import de2_115_qsys_sma_out_pkg::*;
#(
  parameter int   CNT_W       = 16,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
);

  logic        wr;
  logic        data_wr;
  logic        data_bit, data_bit_next;
  logic        out_next;
  logic [31:0] read_next;
  logic        unused_wdata;

  assign wr            = chipselect && !write_n;
  assign data_wr       = wr && (address == ADDR_DATA);
  assign data_bit_next = data_wr ? writedata[0] : data_bit;
  assign unused_wdata  = ^writedata;

`ifdef SMA_OUT_PULSE_EN
  logic             ctrl_wr, high_wr, low_wr;
  logic             mode, cont, mode_next;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic             busy, active_next, level_next;

  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign high_wr   = wr && (address == ADDR_HIGH_CNT);
  assign low_wr    = wr && (address == ADDR_LOW_CNT);
  assign mode_next = ctrl_wr ? writedata[CTRL_MODE_BIT] : mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= 1'b0;
      cont     <= 1'b0;
      high_cnt <= CNT_W'(1);
      low_cnt  <= CNT_W'(1);
    end else begin
      if (ctrl_wr) begin
        mode <= writedata[CTRL_MODE_BIT];
        cont <= writedata[CTRL_CONT_BIT];
      end
      if (high_wr) high_cnt <= writedata[CNT_W-1:0];
      if (low_wr)  low_cnt  <= writedata[CNT_W-1:0];
    end
  end

  sma_out_pulse_gen #(
    .CNT_W (CNT_W)
  ) u_pulse_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_wr     (ctrl_wr),
    .start       (writedata[CTRL_START_BIT]),
    .stop        (writedata[CTRL_STOP_BIT]),
    .run         (writedata[CTRL_MODE_BIT]),
    .cont        (cont),
    .high_cnt    (high_cnt),
    .low_cnt     (low_cnt),
    .busy        (busy),
    .active_next (active_next),
    .level_next  (level_next)
  );

  // out_port is registered from next-state values so that it changes at the
  // same edge that samples the write (START, STOP or DATA).
  assign out_next = active_next ? level_next : (mode_next ? 1'b0 : data_bit_next);

  always_comb begin
    read_next = '0;
    case (address)
      ADDR_DATA: read_next[0] = out_port;
      ADDR_CTRL: begin
        read_next[CTRL_BUSY_BIT] = busy;
        read_next[CTRL_CONT_BIT] = cont;
        read_next[CTRL_MODE_BIT] = mode;
      end
      ADDR_HIGH_CNT: read_next = 32'(high_cnt);
      ADDR_LOW_CNT:  read_next = 32'(low_cnt);
      default:       read_next = '0;
    endcase
  end
`else
  assign out_next = data_bit_next;

  always_comb begin
    read_next = '0;
    if (address == ADDR_DATA) read_next[0] = out_port;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_bit <= RESET_VALUE;
      out_port <= RESET_VALUE;
      readdata <= '0;
    end else begin
      data_bit <= data_bit_next;
      out_port <= out_next;
      readdata <= read_next;
    end
  end

endmodule
